// File: rtl/mpp_pkg.sv
// Shared definitions for the MPP hover-coil DAC path: envelope state
// encoding, unity gain code and the DAC midscale helper.
package mpp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } env_state_e;

  localparam int unsigned UNITY_GAIN = 128;

  // Offset-binary code for a zero sample.
  function automatic int unsigned midscale(input int unsigned dac_w);
    return 32'd1 << (dac_w - 32'd1);
  endfunction

endpackage

// File: rtl/mpp_sat_offset.sv
// Combinational clamp of a wide signed value into the DAC range, conversion
// to offset binary, and a strobe flagging that clipping occurred.
module mpp_sat_offset #(
  parameter int unsigned IN_W  = 40,
  parameter int unsigned DAC_W = 12
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic        [DAC_W-1:0] o_code_c,
  output logic                    o_clip_c
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((32'd1 << (DAC_W - 32'd1)) - 32'd1);
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  logic [DAC_W-1:0] w_clamped;

  always_comb begin
    w_clamped = i_val[DAC_W-1:0];
    o_clip_c  = 1'b0;
    if (i_val > MAX_V) begin
      w_clamped = MAX_V[DAC_W-1:0];
      o_clip_c  = 1'b1;
    end else if (i_val < MIN_V) begin
      w_clamped = MIN_V[DAC_W-1:0];
      o_clip_c  = 1'b1;
    end
  end

  // Two's complement to offset binary is an MSB flip.
  assign o_code_c = {~w_clamped[DAC_W-1], w_clamped[DAC_W-2:0]};

endmodule

// File: rtl/mpp_dac_shaper.sv
// Gain, soft-start/stop envelope and saturation stage between the MPP
// sample generator and the hover-coil DAC; fixed 3-cycle pipeline.
module mpp_dac_shaper
  import mpp_pkg::*;
#(
  parameter int unsigned IN_W      = 24,
  parameter int unsigned DAC_W     = 12,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned RAMP_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [IN_W-1:0]   sample_in,
  input  logic              sample_vld,
  input  logic [GAIN_W-1:0] gain,
  input  logic              sat_clr,
  output logic [DAC_W-1:0]  dac_code,
  output logic              dac_vld,
  output logic              busy,
  output logic              sat_flag
);

  localparam int unsigned PROD_W     = IN_W + GAIN_W + 1;
  localparam int unsigned ENV_W      = RAMP_LOG2 + 1;
  localparam int unsigned P2_W       = PROD_W + ENV_W + 1;
  localparam int unsigned GAIN_SHIFT = $clog2(UNITY_GAIN);
  localparam logic [ENV_W-1:0] ENV_MAX = ENV_W'(32'd1 << RAMP_LOG2);
  localparam logic [DAC_W-1:0] MID     = DAC_W'(midscale(DAC_W));

  env_state_e               r_state, w_state_n;
  logic [ENV_W-1:0]         r_env, w_env_n;
  logic                     r_busy;

  logic signed [PROD_W-1:0] w_smp_x, w_gain_x, w_prod1, r_p1;
  logic [ENV_W-1:0]         r_env1;
  logic signed [P2_W-1:0]   w_p1_x, w_env_x, w_prod2, r_p2;
  logic                     r_v1, r_v2, r_v3;
  logic [DAC_W-1:0]         w_code, r_code;
  logic                     w_clip, r_sat;

  // Envelope next state: transition on en first, then step env in the new direction.
  always_comb begin
    w_state_n = r_state;
    w_env_n   = r_env;
    case (r_state)
      ST_IDLE:      if (en)  w_state_n = ST_RAMP_UP;
      ST_RAMP_UP:   if (!en) w_state_n = ST_RAMP_DOWN;
      ST_ACTIVE:    if (!en) w_state_n = ST_RAMP_DOWN;
      ST_RAMP_DOWN: if (en)  w_state_n = ST_RAMP_UP;
      default:               w_state_n = ST_IDLE;
    endcase
    if (sample_vld) begin
      case (w_state_n)
        ST_RAMP_UP, ST_ACTIVE: if (r_env != ENV_MAX) w_env_n = r_env + ENV_W'(1);
        ST_RAMP_DOWN:          if (r_env != '0)      w_env_n = r_env - ENV_W'(1);
        default:               w_env_n = '0;
      endcase
    end
    if (w_state_n == ST_RAMP_UP && w_env_n == ENV_MAX) w_state_n = ST_ACTIVE;
    if (w_state_n == ST_RAMP_DOWN && w_env_n == '0)    w_state_n = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_env   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_env   <= w_env_n;
      r_busy  <= (w_state_n != ST_IDLE);
    end
  end

  assign w_smp_x  = {{(PROD_W-IN_W){sample_in[IN_W-1]}}, sample_in};
  assign w_gain_x = {{(PROD_W-GAIN_W){1'b0}}, gain};
  assign w_prod1  = w_smp_x * w_gain_x;

  assign w_p1_x   = {{(P2_W-PROD_W){r_p1[PROD_W-1]}}, r_p1};
  assign w_env_x  = {{(P2_W-ENV_W){1'b0}}, r_env1};
  assign w_prod2  = w_p1_x * w_env_x;

  mpp_sat_offset #(
    .IN_W  (P2_W),
    .DAC_W (DAC_W)
  ) u_sat (
    .i_val    (r_p2),
    .o_code_c (w_code),
    .o_clip_c (w_clip)
  );

  // S1 gain, S2 envelope (env before this sample's step), S3 clamp/offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1   <= '0;
      r_env1 <= '0;
      r_v1   <= 1'b0;
      r_p2   <= '0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_code <= MID;
      r_sat  <= 1'b0;
    end else begin
      r_p1   <= w_prod1 >>> GAIN_SHIFT;
      r_env1 <= r_env;
      r_v1   <= sample_vld;
      r_p2   <= w_prod2 >>> RAMP_LOG2;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      if (r_v2) r_code <= w_code;
      if (r_v2 && w_clip) r_sat <= 1'b1;
      else if (sat_clr)   r_sat <= 1'b0;
    end
  end

  assign dac_code = r_code;
  assign dac_vld  = r_v3;
  assign busy     = r_busy;
  assign sat_flag = r_sat;

endmodule

// File: tb/tb_mpp_dac_shaper.sv
// Self-checking bench for mpp_dac_shaper: directed scenarios plus random
// traffic against an arithmetic reference model of gain/envelope/clamp.
module tb_mpp_dac_shaper;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic signed [23:0] sample_in;
  logic               sample_vld;
  logic [7:0]         gain;
  logic               sat_clr;
  logic [11:0]        dac_code;
  logic               dac_vld;
  logic               busy;
  logic               sat_flag;

  mpp_dac_shaper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sample_in  (sample_in),
    .sample_vld (sample_vld),
    .gain       (gain),
    .sat_clr    (sat_clr),
    .dac_code   (dac_code),
    .dac_vld    (dac_vld),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: env moves toward 32 while en, toward 0 otherwise.
  int          m_env;
  bit          m_vld  [3];
  logic [11:0] m_code [3];
  bit          m_clip [3];
  logic        e_vld, e_busy, e_sat;
  logic [11:0] e_code;

  logic [14:0] w_obs;
  logic [14:0] e_vec;
  assign w_obs = {dac_vld, busy, sat_flag, dac_code};
  assign e_vec = {e_vld, e_busy, e_sat, e_code};

  task automatic model_reset();
    m_env  = 0;
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = 0; m_code[i] = 12'h800; m_clip[i] = 0;
    end
    e_vld = 0; e_busy = 0; e_sat = 0; e_code = 12'h800;
  endtask

  task automatic tick(input logic v, input logic signed [23:0] s, input logic [7:0] g,
                      input logic e, input logic c);
    longint p1, p2;
    bit clip;
    sample_vld = v; sample_in = s; gain = g; en = e; sat_clr = c;
    @(posedge clk);
    p1 = (longint'(s) * longint'(g)) >>> 7;
    p2 = (p1 * longint'(m_env)) >>> 5;
    clip = 0;
    if (p2 > 2047)       begin p2 = 2047;  clip = 1; end
    else if (p2 < -2048) begin p2 = -2048; clip = 1; end
    for (int i = 2; i > 0; i--) begin
      m_vld[i] = m_vld[i-1]; m_code[i] = m_code[i-1]; m_clip[i] = m_clip[i-1];
    end
    m_vld[0] = v; m_code[0] = 12'(p2 + 2048); m_clip[0] = clip;
    e_vld = m_vld[2];
    if (m_vld[2]) e_code = m_code[2];
    if (m_vld[2] && m_clip[2]) e_sat = 1;
    else if (c)                e_sat = 0;
    if (v) m_env = e ? ((m_env < 32) ? m_env + 1 : 32) : ((m_env > 0) ? m_env - 1 : 0);
    e_busy = e || (m_env != 0);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; sample_in = '0; sample_vld = 0; gain = 8'd128; sat_clr = 0;
    model_reset();
    #12;
    n_vec++;
    if (w_obs !== 15'h0800) begin
      n_err++; $display("FAIL reset got %h want %h", w_obs, 15'h0800);
    end
    rst_n = 1;
  endtask

  task automatic test_ramp_up();
    for (int i = 0; i < 40; i++) begin
      tick(1, 24'sd1920, 8'd128, 1, 0);
      n_vec++;
      if (w_obs !== e_vec) begin
        n_err++; $display("FAIL ramp_up model i=%0d got %h want %h", i, w_obs, e_vec);
      end
      n_vec++;
      if ((i == 0 && busy !== 1'b1) ||
          (i == 2 && {dac_vld, dac_code} !== {1'b1, 12'h800}) ||
          (i == 3 && {dac_vld, dac_code} !== {1'b1, 12'h83C}) ||
          (i >= 34 && {dac_vld, dac_code} !== {1'b1, 12'hF80})) begin
        n_err++; $display("FAIL ramp_up directed i=%0d got vld=%b busy=%b code=%h", i, dac_vld, busy, dac_code);
      end
    end
  endtask

  task automatic test_active_latency();
    logic signed [23:0] s;
    for (int k = 0; k < 5; k++) begin
      s = (k == 0) ? -24'sd1920 : 24'sd0;
      tick(1, s, 8'd128, 1, 0);
      n_vec++;
      if (w_obs !== e_vec) begin
        n_err++; $display("FAIL latency model k=%0d got %h want %h", k, w_obs, e_vec);
      end
      n_vec++;
      if ((k == 1 && dac_code !== 12'hF80) || (k == 2 && dac_code !== 12'h080) ||
          (k == 3 && dac_code !== 12'h800)) begin
        n_err++; $display("FAIL latency directed k=%0d got %h", k, dac_code);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [23:0] ts [10];
    logic [7:0]         tg [10];
    logic               tc [10];
    ts = '{24'sd1920, 0, 0, 0, 24'sd1920, 0, 0, -24'sd1920, 0, 0};
    tg = '{8'd255, 128, 128, 128, 8'd255, 128, 128, 8'd255, 128, 128};
    tc = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    for (int k = 0; k < 10; k++) begin
      tick(1, ts[k], tg[k], 1, tc[k]);
      n_vec++;
      if (w_obs !== e_vec) begin
        n_err++; $display("FAIL sat model k=%0d got %h want %h", k, w_obs, e_vec);
      end
      n_vec++;
      if ((k == 2 && {dac_code, sat_flag} !== {12'hFFF, 1'b1}) ||
          (k == 3 && sat_flag !== 1'b0) ||
          (k == 6 && {dac_code, sat_flag} !== {12'hFFF, 1'b1}) ||
          (k == 9 && {dac_code, sat_flag} !== {12'h000, 1'b1})) begin
        n_err++; $display("FAIL sat directed k=%0d got code=%h sat=%b", k, dac_code, sat_flag);
      end
    end
  endtask

  task automatic test_reset_mid_active();
    for (int i = 0; i < 40; i++) begin
      tick(1, 24'sd500, 8'd128, 1, 0);
      n_vec++;
      if (w_obs !== e_vec) begin
        n_err++; $display("FAIL pre_reset model i=%0d got %h want %h", i, w_obs, e_vec);
      end
    end
    #2 rst_n = 0;
    #1;
    n_vec++;
    if (w_obs !== 15'h0800) begin
      n_err++; $display("FAIL reset_mid got %h want %h", w_obs, 15'h0800);
    end
    en = 0; sample_vld = 0;
    model_reset();
    #2 rst_n = 1;
  endtask

  task automatic test_envelope_reversal();
    int j;
    bit done;
    for (int i = 0; i < 20; i++) begin
      j = i - 16;
      tick(1, 24'sd64, 8'd128, (i < 10) || (i >= 16), 0);
      n_vec++;
      if (w_obs !== e_vec) begin
        n_err++; $display("FAIL env model i=%0d got %h want %h", i, w_obs, e_vec);
      end
      n_vec++;
      if ((i == 11 && dac_code !== 12'h812) || (i == 12 && dac_code !== 12'h814) ||
          (i == 13 && dac_code !== 12'h812) || (j == 2 && dac_code !== 12'h808) ||
          (j == 3 && dac_code !== 12'h80A)) begin
        n_err++; $display("FAIL env directed i=%0d got %h", i, dac_code);
      end
    end
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick(1, 24'sd64, 8'd128, 0, 0);
      n_vec++;
      if (w_obs !== e_vec) begin
        n_err++; $display("FAIL env_down model i=%0d got %h want %h", i, w_obs, e_vec);
      end
      if (!busy) done = 1;
    end
    n_vec++;
    if (!done || dac_vld !== 1'b1) begin
      n_err++; $display("FAIL env_idle busy=%b vld=%b want 0/1", busy, dac_vld);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 24'sd64, 8'd128, 0, 0);
      n_vec++;
      if (w_obs !== e_vec || (i >= 2 && dac_code !== 12'h800)) begin
        n_err++; $display("FAIL env_idle_pass i=%0d got %h want %h", i, w_obs, e_vec);
      end
    end
  endtask

  task automatic test_sparse_valid();
    logic vh [24];
    for (int i = 0; i < 24; i++) begin
      vh[i] = (i % 2 == 0);
      tick(vh[i], 24'sd1000, 8'd128, 1, 0);
      n_vec++;
      if (w_obs !== e_vec) begin
        n_err++; $display("FAIL sparse model i=%0d got %h want %h", i, w_obs, e_vec);
      end
      if (i >= 2) begin
        n_vec++;
        if (dac_vld !== vh[i-2]) begin
          n_err++; $display("FAIL sparse vld i=%0d got %b want %b", i, dac_vld, vh[i-2]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic               v, e, c;
    logic signed [23:0] s;
    logic [7:0]         g;
    e = 0;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) e = ~e;
      c = ($urandom_range(0, 9) == 0);
      g = 8'($urandom);
      if ($urandom_range(0, 3) == 0) s = 24'($urandom);
      else                           s = 24'($signed($urandom_range(0, 8191)) - 4096);
      tick(v, s, g, e, c);
      n_vec++;
      if (w_obs !== e_vec) begin
        n_err++; $display("FAIL random i=%0d got %h want %h", i, w_obs, e_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_active_latency();
    test_saturation();
    test_reset_mid_active();
    test_envelope_reversal();
    test_sparse_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
